// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Brief    : Opcodes, immediate-source encodings and decoded-entry type.
// Revision : 1.0
// ============================================================================
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b101;

    // XLEN-independent part of a decoded entry; pc and imm are kept alongside.
    typedef struct packed {
        logic [2:0] imm_src;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [6:0] opcode;
        logic       illegal;
    } dec_fields_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : Fetch-side and execute-side handshake bundle of the decode stage.
// Revision : 1.0
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_src;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [6:0]      out_opcode;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_imm_src, out_rd,
               out_rs1, out_rs2, out_funct3, out_funct7, out_opcode, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_imm_src, out_rd,
               out_rs1, out_rs2, out_funct3, out_funct7, out_opcode, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational immediate generator and opcode legality check.
// Revision : 1.0
// ============================================================================
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_COMPRESSED = 1'b0
) (
    input  logic [31:0]     i_instr,
    output logic [2:0]      o_imm_src,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);
    logic [31:0] w_imm32;

    always_comb begin
        w_imm32   = '0;
        o_imm_src = IMM_I;
        o_illegal = 1'b0;
        if (i_instr[1:0] != 2'b11 && !ALLOW_COMPRESSED) begin
            o_illegal = 1'b1;
        end else begin
            case (i_instr[6:0])
                OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                end
                OP_STORE: begin
                    o_imm_src = IMM_S;
                    w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                end
                OP_BRANCH: begin
                    o_imm_src = IMM_B;
                    w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                 i_instr[30:25], i_instr[11:8], 1'b0};
                end
                OP_JAL: begin
                    o_imm_src = IMM_J;
                    w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                 i_instr[20], i_instr[30:21], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    o_imm_src = IMM_U;
                    w_imm32   = {i_instr[31:12], 12'b0};
                end
                OP_REG: begin
                    o_imm_src = IMM_NONE;
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

    // Bit 31 of every format is instr[31], so widening sign-extends from it.
    assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered instruction decode with valid/ready and a skid entry.
// Revision : 1.0
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_COMPRESSED = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     flush,
    decode_stage_if.slave bus
);
    logic [2:0]      w_imm_src;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    dec_fields_t     w_fields;
    logic            w_accept;
    logic            w_drain;

    logic            r_main_valid;
    logic            r_skid_valid;
    dec_fields_t     r_main_f;
    dec_fields_t     r_skid_f;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_main_imm;
    logic [XLEN-1:0] r_skid_imm;

    imm_gen #(
        .XLEN             (XLEN),
        .ALLOW_COMPRESSED (ALLOW_COMPRESSED)
    ) u_imm_gen (
        .i_instr   (bus.in_instr),
        .o_imm_src (w_imm_src),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    assign w_fields = '{
        imm_src: w_imm_src,
        rd:      bus.in_instr[11:7],
        rs1:     bus.in_instr[19:15],
        rs2:     bus.in_instr[24:20],
        funct3:  bus.in_instr[14:12],
        funct7:  bus.in_instr[31:25],
        opcode:  bus.in_instr[6:0],
        illegal: w_illegal
    };

    // in_ready depends only on skid occupancy, so it never combinationally
    // follows out_ready.
    assign w_accept = bus.in_valid && !r_skid_valid;
    assign w_drain  = r_main_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_f     <= '0;
            r_skid_f     <= '0;
            r_main_pc    <= '0;
            r_skid_pc    <= '0;
            r_main_imm   <= '0;
            r_skid_imm   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain && r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_f     <= r_skid_f;
            r_main_pc    <= r_skid_pc;
            r_main_imm   <= r_skid_imm;
            r_skid_valid <= 1'b0;
        end else if (w_drain || !r_main_valid) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main_f   <= w_fields;
                r_main_pc  <= bus.in_pc;
                r_main_imm <= w_imm;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_f     <= w_fields;
            r_skid_pc    <= bus.in_pc;
            r_skid_imm   <= w_imm;
        end
    end

    assign bus.in_ready    = !r_skid_valid;
    assign bus.out_valid   = r_main_valid;
    assign bus.out_pc      = r_main_pc;
    assign bus.out_imm     = r_main_imm;
    assign bus.out_imm_src = r_main_f.imm_src;
    assign bus.out_rd      = r_main_f.rd;
    assign bus.out_rs1     = r_main_f.rs1;
    assign bus.out_rs2     = r_main_f.rs2;
    assign bus.out_funct3  = r_main_f.funct3;
    assign bus.out_funct7  = r_main_f.funct7;
    assign bus.out_opcode  = r_main_f.opcode;
    assign bus.out_illegal = r_main_f.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Vector table plus scoreboard bench for decode_stage (XLEN=32).
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  src;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] pc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic last_acc;
    exp_t sb[$];
    vec_t vecs[12];
    vec_t idle;
    logic [31:0] pc_ctr = 32'h0000_1000;

    decode_stage_if #(.XLEN(XLEN)) bus ();

    decode_stage #(
        .XLEN             (XLEN),
        .ALLOW_COMPRESSED (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty_drain: got out_valid=1 (imm 0x%0h) expected no output", bus.out_imm);
            return;
        end
        e = sb.pop_front();
        chk("out_pc",      bus.out_pc, e.pc);
        chk("out_imm",     bus.out_imm, e.v.imm);
        chk("out_imm_src", bus.out_imm_src, e.v.src);
        chk("out_illegal", bus.out_illegal, e.v.ill);
        chk("out_fields",
            {bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_funct7, bus.out_opcode},
            {e.v.instr[11:7], e.v.instr[19:15], e.v.instr[24:20], e.v.instr[14:12],
             e.v.instr[31:25], e.v.instr[6:0]});
    endtask

    // Called at a negedge: drive, evaluate the coming edge's handshakes, advance.
    task automatic cycle(input logic v, input vec_t vec, input logic ordy, input logic fl);
        exp_t e;
        bus.in_valid  = v;
        bus.in_instr  = vec.instr;
        bus.in_pc     = pc_ctr;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        last_acc = 1'b0;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && !fl) sb_compare();
            if (fl) begin
                sb.delete();
            end else if (v && bus.in_ready) begin
                e.v  = vec;
                e.pc = pc_ctr;
                sb.push_back(e);
                last_acc = 1'b1;
                pc_ctr   = pc_ctr + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain_all();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            cycle(1'b0, idle, 1'b1, 1'b0);
            k++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        idle = '{instr: 32'h0, imm: 32'h0, src: 3'b000, ill: 1'b1};
        vecs[0]  = '{instr: 32'hFFF10093, imm: 32'hFFFFFFFF, src: 3'b000, ill: 1'b0}; // addi
        vecs[1]  = '{instr: 32'h00512423, imm: 32'h00000008, src: 3'b001, ill: 1'b0}; // sw
        vecs[2]  = '{instr: 32'hFFDFF0EF, imm: 32'hFFFFFFFC, src: 3'b011, ill: 1'b0}; // jal
        vecs[3]  = '{instr: 32'h123451B7, imm: 32'h12345000, src: 3'b100, ill: 1'b0}; // lui
        vecs[4]  = '{instr: 32'hFE000EE3, imm: 32'hFFFFFFFC, src: 3'b010, ill: 1'b0}; // beq
        vecs[5]  = '{instr: 32'h00001017, imm: 32'h00001000, src: 3'b100, ill: 1'b0}; // auipc
        vecs[6]  = '{instr: 32'h80002283, imm: 32'hFFFFF800, src: 3'b000, ill: 1'b0}; // lw
        vecs[7]  = '{instr: 32'h7FF080E7, imm: 32'h000007FF, src: 3'b000, ill: 1'b0}; // jalr
        vecs[8]  = '{instr: 32'h0FF0000F, imm: 32'h000000FF, src: 3'b000, ill: 1'b0}; // fence
        vecs[9]  = '{instr: 32'h00000033, imm: 32'h00000000, src: 3'b101, ill: 1'b0}; // add
        vecs[10] = '{instr: 32'h0000007F, imm: 32'h00000000, src: 3'b000, ill: 1'b1}; // bad op
        vecs[11] = '{instr: 32'h00000012, imm: 32'h00000000, src: 3'b000, ill: 1'b1}; // low bits 10

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset held two edges with input offered.
        rst_n = 1'b0;
        cycle(1'b1, vecs[0], 1'b1, 1'b0);
        cycle(1'b1, vecs[0], 1'b1, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_imm",   bus.out_imm, 32'h0);
        chk("rst_in_ready",  bus.in_ready, 1'b1);
        rst_n = 1'b1;
        chk("rel_in_ready",  bus.in_ready, 1'b1);

        // Streaming table, one per cycle, downstream always ready.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, vecs[i], 1'b1, 1'b0);
            chk("stream_accept", last_acc, 1'b1);
        end
        drain_all();

        // Back-pressure: sw, jal fill main and skid; lui waits.
        cycle(1'b1, vecs[1], 1'b0, 1'b0);
        cycle(1'b1, vecs[2], 1'b0, 1'b0);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, vecs[3], 1'b0, 1'b0);
            chk("bp_lui_blocked", last_acc, 1'b0);
            chk("bp_sw_held_imm", bus.out_imm, 32'h8);
            chk("bp_sw_held_vld", bus.out_valid, 1'b1);
        end
        begin
            int k;
            k = 0;
            do begin
                cycle(1'b1, vecs[3], 1'b1, 1'b0);
                k++;
            end while (!last_acc && k < 8);
            chk("bp_lui_accepted", last_acc, 1'b1);
        end
        drain_all();

        // Flush with main and skid full; the flushed-cycle input must vanish.
        cycle(1'b1, vecs[4], 1'b0, 1'b0);
        cycle(1'b1, vecs[5], 1'b0, 1'b0);
        chk("fl_in_ready_low", bus.in_ready, 1'b0);
        cycle(1'b1, vecs[6], 1'b0, 1'b1);
        chk("fl_out_valid", bus.out_valid, 1'b0);
        chk("fl_in_ready",  bus.in_ready, 1'b1);
        cycle(1'b1, vecs[7], 1'b0, 1'b1);
        chk("fl_empty_out_valid", bus.out_valid, 1'b0);
        cycle(1'b1, vecs[8], 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        drain_all();
        chk("fl_after_idle", bus.out_valid, 1'b0);

        // Reset while an entry is held under back-pressure.
        cycle(1'b1, vecs[0], 1'b0, 1'b0);
        chk("mr_held_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        cycle(1'b0, idle, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("mr_out_valid", bus.out_valid, 1'b0);
        chk("mr_out_imm",   bus.out_imm, 32'h0);
        chk("mr_out_pc",    bus.out_pc, 32'h0);
        chk("mr_out_misc",
            {bus.out_imm_src, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3,
             bus.out_funct7, bus.out_opcode, bus.out_illegal}, 64'h0);
        chk("mr_in_ready",  bus.in_ready, 1'b1);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        chk("mr_entry_gone", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion expected finish before 50000");
        $fatal(1);
    end

endmodule
`default_nettype wire
